// File: rtl/mkio_bc_control.sv
`default_nettype none
// ============================================================================
// Module   : mkio_bc_control
// Brief    : Bus-controller transaction sequencer: command, data, status, RX.
// Revision : 1.0 - initial release
// ============================================================================
module mkio_bc_control #(
  parameter logic [15:0] TIMEOUT = 16'd1400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  subaddr,
  input  logic        dir,
  input  logic [4:0]  word_count,
  output logic [4:0]  buf_addr,
  input  logic [15:0] buf_rdata,
  output logic [15:0] buf_wdata,
  output logic        buf_we,
  output logic        tx_ready,
  output logic [15:0] tx_data,
  output logic        tx_cd,
  input  logic        tx_busy,
  input  logic        rx_done,
  input  logic [15:0] rx_data,
  input  logic        rx_cd,
  input  logic        p_error,
  output logic        busy,
  output logic        done,
  output logic [15:0] status_word,
  output logic        err_timeout,
  output logic        err_parity,
  output logic        err_addr,
  output logic        err_format
);

  localparam logic [2:0] c_idle        = 3'd0;
  localparam logic [2:0] c_send_cmd    = 3'd1;
  localparam logic [2:0] c_wait_tx     = 3'd2;
  localparam logic [2:0] c_fetch       = 3'd3;
  localparam logic [2:0] c_send_data   = 3'd4;
  localparam logic [2:0] c_wait_status = 3'd5;
  localparam logic [2:0] c_rx_data     = 3'd6;
  localparam logic [2:0] c_finish      = 3'd7;

  logic [2:0]  r_state;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_subaddr;
  logic        r_dir;
  logic [5:0]  r_n;
  logic [5:0]  r_idx;
  logic [15:0] r_timer;
  logic        r_seen_busy;
  logic        r_data_phase;

  logic [4:0]  r_buf_addr;
  logic [15:0] r_buf_wdata;
  logic        r_buf_we;
  logic        r_tx_ready;
  logic [15:0] r_tx_data;
  logic        r_tx_cd;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_status_word;
  logic        r_err_timeout;
  logic        r_err_parity;
  logic        r_err_addr;
  logic        r_err_format;

  logic [5:0]  w_idx_next;
  logic        w_timer_expired;

  assign w_idx_next      = r_idx + 6'd1;
  assign w_timer_expired = (r_timer == TIMEOUT - 16'd1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= c_idle;
      r_rt_addr     <= 5'd0;
      r_subaddr     <= 5'd0;
      r_dir         <= 1'b0;
      r_n           <= 6'd0;
      r_idx         <= 6'd0;
      r_timer       <= 16'd0;
      r_seen_busy   <= 1'b0;
      r_data_phase  <= 1'b0;
      r_buf_addr    <= 5'd0;
      r_buf_wdata   <= 16'd0;
      r_buf_we      <= 1'b0;
      r_tx_ready    <= 1'b0;
      r_tx_data     <= 16'd0;
      r_tx_cd       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_status_word <= 16'd0;
      r_err_timeout <= 1'b0;
      r_err_parity  <= 1'b0;
      r_err_addr    <= 1'b0;
      r_err_format  <= 1'b0;
    end else begin
      r_tx_ready <= 1'b0;
      r_buf_we   <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        c_idle: begin
          if (start) begin
            r_rt_addr     <= rt_addr;
            r_subaddr     <= subaddr;
            r_dir         <= dir;
            r_n           <= (word_count == 5'd0) ? 6'd32 : {1'b0, word_count};
            r_idx         <= 6'd0;
            r_err_timeout <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_addr    <= 1'b0;
            r_err_format  <= 1'b0;
            r_busy        <= 1'b1;
            r_state       <= c_send_cmd;
          end
        end
        c_send_cmd: begin
          if (!tx_busy) begin
            r_tx_ready   <= 1'b1;
            r_tx_data    <= {r_rt_addr, r_dir, r_subaddr, r_n[4:0]};
            r_tx_cd      <= 1'b0;
            r_seen_busy  <= 1'b0;
            r_data_phase <= 1'b0;
            r_state      <= c_wait_tx;
          end
        end
        c_wait_tx: begin
          // A word is finished only after busy has been seen high and then low.
          if (tx_busy) begin
            r_seen_busy <= 1'b1;
          end else if (r_seen_busy) begin
            if (r_data_phase ? (r_idx == r_n) : r_dir) begin
              r_timer <= 16'd0;
              r_state <= c_wait_status;
            end else begin
              r_buf_addr <= r_idx[4:0];
              r_state    <= c_fetch;
            end
          end
        end
        c_fetch: r_state <= c_send_data;
        c_send_data: begin
          if (!tx_busy) begin
            r_tx_ready   <= 1'b1;
            r_tx_data    <= buf_rdata;
            r_tx_cd      <= 1'b1;
            r_idx        <= w_idx_next;
            r_seen_busy  <= 1'b0;
            r_data_phase <= 1'b1;
            r_state      <= c_wait_tx;
          end
        end
        c_wait_status: begin
          if (rx_done) begin
            if (p_error) begin
              r_err_parity <= 1'b1;
              r_state      <= c_finish;
            end else if (rx_cd) begin
              r_err_format <= 1'b1;
              r_state      <= c_finish;
            end else begin
              r_status_word <= rx_data;
              if (rx_data[15:11] != r_rt_addr) begin
                r_err_addr <= 1'b1;
                r_state    <= c_finish;
              end else if (r_dir) begin
                r_idx   <= 6'd0;
                r_timer <= 16'd0;
                r_state <= c_rx_data;
              end else begin
                r_state <= c_finish;
              end
            end
          end else if (w_timer_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= c_finish;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        c_rx_data: begin
          if (rx_done) begin
            if (p_error) begin
              r_err_parity <= 1'b1;
              r_state      <= c_finish;
            end else if (!rx_cd) begin
              r_err_format <= 1'b1;
              r_state      <= c_finish;
            end else begin
              r_buf_we    <= 1'b1;
              r_buf_addr  <= r_idx[4:0];
              r_buf_wdata <= rx_data;
              r_idx       <= w_idx_next;
              r_timer     <= 16'd0;
              if (w_idx_next == r_n) r_state <= c_finish;
            end
          end else if (w_timer_expired) begin
            r_err_timeout <= 1'b1;
            r_state       <= c_finish;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        c_finish: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign buf_addr    = r_buf_addr;
  assign buf_wdata   = r_buf_wdata;
  assign buf_we      = r_buf_we;
  assign tx_ready    = r_tx_ready;
  assign tx_data     = r_tx_data;
  assign tx_cd       = r_tx_cd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign status_word = r_status_word;
  assign err_timeout = r_err_timeout;
  assign err_parity  = r_err_parity;
  assign err_addr    = r_err_addr;
  assign err_format  = r_err_format;

endmodule
`default_nettype wire

// File: tb/tb_mkio_bc_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mkio_bc_control
// Brief    : Scoreboard bench for mkio_bc_control with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mkio_bc_control;

  localparam logic [15:0] c_timeout = 16'd40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rt_addr = 5'd0;
  logic [4:0]  subaddr = 5'd0;
  logic        dir = 1'b0;
  logic [4:0]  word_count = 5'd0;
  logic [4:0]  buf_addr;
  logic [15:0] buf_rdata = 16'd0;
  logic [15:0] buf_wdata;
  logic        buf_we;
  logic        tx_ready;
  logic [15:0] tx_data;
  logic        tx_cd;
  logic        tx_busy = 1'b0;
  logic        rx_done = 1'b0;
  logic [15:0] rx_data = 16'd0;
  logic        rx_cd = 1'b0;
  logic        p_error = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] status_word;
  logic        err_timeout;
  logic        err_parity;
  logic        err_addr;
  logic        err_format;

  mkio_bc_control #(.TIMEOUT(c_timeout)) dut (
    .clk(clk), .reset(reset), .start(start), .rt_addr(rt_addr), .subaddr(subaddr),
    .dir(dir), .word_count(word_count), .buf_addr(buf_addr), .buf_rdata(buf_rdata),
    .buf_wdata(buf_wdata), .buf_we(buf_we), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_cd(tx_cd), .tx_busy(tx_busy), .rx_done(rx_done), .rx_data(rx_data),
    .rx_cd(rx_cd), .p_error(p_error), .busy(busy), .done(done),
    .status_word(status_word), .err_timeout(err_timeout), .err_parity(err_parity),
    .err_addr(err_addr), .err_format(err_format)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: {cd, word}, {addr, data}, {timeout,parity,addr,format, status}
  logic [16:0] exp_tx[$];
  logic [20:0] exp_wr[$];
  logic [19:0] exp_done[$];
  logic [15:0] model_status = 16'd0;
  logic [15:0] mem[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) buf_rdata <= mem[buf_addr];

  // Transmitter model: accepts a word, stays busy a few cycles, then releases.
  int  tx_words = 0;
  int  tx_extra = 0;
  int  fall_cyc = 0;
  bit  tx_idle = 1'b1;
  always begin : tx_model
    logic [16:0] e;
    @(negedge clk);
    if (tx_ready) begin
      tx_words++;
      if (exp_tx.size() == 0) begin
        checks++; failures++;
        $display("FAIL tx_unexpected: actual=%0h required=none", {tx_cd, tx_data});
      end else begin
        e = exp_tx.pop_front();
        check("tx_word", 32'({tx_cd, tx_data}), 32'(e));
      end
      tx_busy = 1'b1;
      tx_idle = 1'b0;
      repeat ($urandom_range(1, 3) + tx_extra) @(negedge clk);
      tx_busy  = 1'b0;
      fall_cyc = cyc;
      tx_idle  = 1'b1;
    end
  end

  int   done_count = 0;
  int   to_rise_cyc = 0;
  logic prev_to = 1'b0;
  always @(negedge clk) begin : monitor
    logic [20:0] w;
    logic [19:0] d;
    if (buf_we) begin
      if (exp_wr.size() == 0) begin
        checks++; failures++;
        $display("FAIL wr_unexpected: actual=%0h required=none", {buf_addr, buf_wdata});
      end else begin
        w = exp_wr.pop_front();
        check("buf_write", 32'({buf_addr, buf_wdata}), 32'(w));
      end
    end
    if (done) begin
      done_count++;
      if (exp_done.size() == 0) begin
        checks++; failures++;
        $display("FAIL done_unexpected: actual=1 required=0");
      end else begin
        d = exp_done.pop_front();
        check("done_status", 32'(status_word), 32'(d[15:0]));
        check("done_errs", 32'({err_timeout, err_parity, err_addr, err_format}), 32'(d[19:16]));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (err_timeout && !prev_to) to_rise_cyc = cyc;
    prev_to = err_timeout;
  end

  task automatic send_rx(input logic [15:0] w, input logic cd, input logic pe);
    rx_data = w; rx_cd = cd; p_error = pe; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; p_error = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
    check({tag, "_buf_we"}, 32'(buf_we), 32'd0);
    check({tag, "_errs"}, 32'({err_timeout, err_parity, err_addr, err_format}), 32'd0);
    check({tag, "_tx"}, 32'({tx_cd, tx_data}), 32'd0);
    check({tag, "_buf"}, 32'({buf_addr, buf_wdata}), 32'd0);
    check({tag, "_status"}, 32'(status_word), 32'd0);
  endtask

  // kind: 0 normal, 1 silent terminal, 2 status with foreign address,
  // 3 parity on status, 4 parity on data k, 5 data sync on status,
  // 6 command sync on data k, 7 terminal stops after k data words.
  task automatic run_txn(input logic [4:0] rt, input logic [4:0] sa, input logic d,
                         input logic [4:0] wc, input int kind, input int k,
                         input logic [15:0] st);
    int n;
    int nwr;
    int d0;
    int tgt;
    logic [3:0]  errs;
    logic [15:0] exp_status;
    logic [15:0] data[32];
    n = (wc == 5'd0) ? 32 : int'(wc);
    for (int i = 0; i < 32; i++) data[i] = 16'($urandom);

    exp_tx.push_back({1'b0, rt, d, sa, wc});
    if (!d) for (int i = 0; i < n; i++) exp_tx.push_back({1'b1, mem[i]});
    errs = 4'b0000; exp_status = model_status; nwr = 0;
    if (kind == 1) errs = 4'b1000;
    else if (kind == 3) errs = 4'b0100;
    else if (kind == 5) errs = 4'b0001;
    else begin
      exp_status = st;
      if (st[15:11] != rt) errs = 4'b0010;
      else if (d) begin
        if (kind == 0) nwr = n;
        else begin
          nwr = k;
          errs = (kind == 4) ? 4'b0100 : (kind == 6) ? 4'b0001 : 4'b1000;
        end
      end
    end
    for (int i = 0; i < nwr; i++) exp_wr.push_back({5'(i), data[i]});
    exp_done.push_back({errs, exp_status});
    model_status = exp_status;

    d0  = done_count;
    tgt = tx_words + (d ? 1 : 1 + n);
    @(negedge clk);
    rt_addr = rt; subaddr = sa; dir = d; word_count = wc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    rt_addr = 5'($urandom); subaddr = 5'($urandom); dir = 1'($urandom); word_count = 5'($urandom);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 3000 && !(tx_words == tgt && tx_idle); i++) @(negedge clk);
    if (!(tx_words == tgt && tx_idle)) begin
      checks++; failures++;
      $display("FAIL tx_wait: actual=%0d words required=%0d", tx_words, tgt);
    end
    repeat ($urandom_range(1, 4)) @(negedge clk);

    if (kind != 1) begin
      send_rx(st, kind == 5, kind == 3);
      if (d && kind != 3 && kind != 5) begin
        int good;
        good = (kind == 0) ? n : (kind == 2) ? 0 : k;
        for (int i = 0; i < good; i++) send_rx(data[i], 1'b1, 1'b0);
        if (kind == 4) send_rx(data[k], 1'b1, 1'b1);
        else if (kind == 6) send_rx(data[k], 1'b0, 1'b0);
        else if (kind == 0 || kind == 2) send_rx(16'($urandom), 1'b1, 1'b0);
      end
    end

    for (int i = 0; i < 3000 && done_count == d0; i++) @(negedge clk);
    if (kind == 1)
      check("timeout_latency", 32'(to_rise_cyc - (fall_cyc + 1)), 32'(c_timeout));
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_count - d0), 32'd1);
  endtask

  initial begin : main
    logic [4:0]  rt;
    logic [4:0]  wc;
    logic        d;
    logic [15:0] st;
    int kind;
    int n;
    int w0;
    int d0;
    for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    mem[0] = 16'hA5A5; mem[1] = 16'h1234;
    run_txn(5'd1, 5'd3, 1'b0, 5'd2, 0, 0, 16'h0800);
    run_txn(5'd1, 5'd5, 1'b1, 5'd0, 0, 0, 16'h0800);
    run_txn(5'd1, 5'd5, 1'b1, 5'd4, 1, 0, 16'h0800);
    run_txn(5'd1, 5'd7, 1'b1, 5'd4, 2, 0, 16'h1000);
    run_txn(5'd1, 5'd2, 1'b1, 5'd3, 4, 1, 16'h0800);

    for (int t = 0; t < 30; t++) begin
      rt = 5'($urandom); d = 1'($urandom); wc = 5'($urandom);
      kind = $urandom_range(0, 7);
      if (!d && (kind == 4 || kind == 6 || kind == 7)) kind = 0;
      n = (wc == 5'd0) ? 32 : int'(wc);
      st = {rt, 11'($urandom)};
      if (kind == 2) st[15:11] = rt ^ 5'($urandom_range(1, 31));
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      run_txn(rt, 5'($urandom), d, wc, kind, $urandom_range(0, n - 1), st);
    end

    // Reset while the command word is still in flight.
    tx_extra = 6;
    exp_tx.push_back({1'b0, 5'd9, 1'b0, 5'd4, 5'd8});
    w0 = tx_words; d0 = done_count;
    @(negedge clk);
    rt_addr = 5'd9; subaddr = 5'd4; dir = 1'b0; word_count = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && tx_words == w0; i++) @(negedge clk);
    check("reset_cmd_sent", 32'(tx_words - w0), 32'd1);
    reset = 1'b0;
    exp_tx.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("tx_busy_still_high", 32'(tx_busy), 32'd1);
    check_idle_outputs("abort");
    repeat (20) @(negedge clk);
    check("no_done_after_reset", 32'(done_count - d0), 32'd0);
    check("idle_after_reset", 32'(busy), 32'd0);
    tx_extra = 0;

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: actual=expired required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
